// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared types and widths for the ALU reservation station
//
// Purpose: common widths, the tag-width helper and the per-entry record
// used by alu_reservation_station and rs_slot.
//   CMD_W   : width of the dispatched command word (ALU control in [4:2])
//   DATA_W  : operand / result width
//   tag_w() : ROB tag width for a given ROB size (one extra code point)
//   rs_src_t   : {rdy, val}; when rdy=0 the low tag bits of val hold the producer tag
//   rs_entry_t : {valid, cmd, src1, src2, val3}
package issue_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 64;

  function automatic int tag_w(input int rob_size);
    return $clog2(rob_size + 1);
  endfunction

  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic              valid;
    logic [CMD_W-1:0]  cmd;
    rs_src_t           src1;
    rs_src_t           src2;
    logic [DATA_W-1:0] val3;
  } rs_entry_t;

endpackage

// File: rtl/rs_slot.sv
// rtl/rs_slot.sv - one reservation station entry with CDB snoop
//
// Purpose: holds a single renamed ALU op. Written on dispatch, resolves
// its unready sources from the CDB, cleared when the op is issued.
// Optional macro: RS_DISPATCH_BYPASS_EN - a source written unready whose
// tag matches the same-cycle CDB broadcast is captured as ready.
// Ports:
//   clk_i, reset_i         : clock, synchronous active-high reset
//   wr_i, wr_*_i           : dispatch write strobe and entry contents
//   clr_i                  : issue accepted from this entry
//   cdb_valid_i/tag_i/val_i: common data bus broadcast
//   entry_o, tag_o         : registered entry state and destination tag
//   ready_o                : valid with both sources ready
module rs_slot
  import issue_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_i,
  input  logic [CMD_W-1:0]  wr_cmd_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  rs_src_t           wr_src1_i,
  input  rs_src_t           wr_src2_i,
  input  logic [DATA_W-1:0] wr_val3_i,
  input  logic              clr_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_val_i,
  output rs_entry_t         entry_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              ready_o
);

  rs_entry_t        entry_q, entry_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // A waiting source picks up the broadcast value when its producer tag matches.
  function automatic rs_src_t snoop(input rs_src_t s, input logic cv,
                                    input logic [TAG_W-1:0] ct,
                                    input logic [DATA_W-1:0] cval);
    rs_src_t r;
    r = s;
    if (!s.rdy && cv && (s.val[TAG_W-1:0] == ct)) begin
      r.rdy = 1'b1;
      r.val = cval;
    end
    return r;
  endfunction

  always_comb begin
    entry_d = entry_q;
    tag_d   = tag_q;
    if (wr_i) begin
      entry_d.valid = 1'b1;
      entry_d.cmd   = wr_cmd_i;
      entry_d.val3  = wr_val3_i;
      tag_d         = wr_tag_i;
`ifdef RS_DISPATCH_BYPASS_EN
      entry_d.src1  = snoop(wr_src1_i, cdb_valid_i, cdb_tag_i, cdb_val_i);
      entry_d.src2  = snoop(wr_src2_i, cdb_valid_i, cdb_tag_i, cdb_val_i);
`else
      entry_d.src1  = wr_src1_i;
      entry_d.src2  = wr_src2_i;
`endif
    end else if (clr_i) begin
      // The issuing entry is already fully ready, so no snoop is needed here.
      entry_d.valid = 1'b0;
    end else if (entry_q.valid) begin
      entry_d.src1 = snoop(entry_q.src1, cdb_valid_i, cdb_tag_i, cdb_val_i);
      entry_d.src2 = snoop(entry_q.src2, cdb_valid_i, cdb_tag_i, cdb_val_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entry_q <= '0;
      tag_q   <= '0;
    end else begin
      entry_q <= entry_d;
      tag_q   <= tag_d;
    end
  end

  assign entry_o = entry_q;
  assign tag_o   = tag_q;
  assign ready_o = entry_q.valid & entry_q.src1.rdy & entry_q.src2.rdy;

endmodule

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - multi-entry ALU reservation station
//
// Purpose: accepts renamed ALU ops, snoops the CDB for operand tags and
// presents the lowest-index fully-ready entry to the issue stage. The entry
// is released only on a cycle where the issue stage is not stalling.
// Optional macro: RS_DISPATCH_BYPASS_EN (see rs_slot).
// Ports:
//   clk_i, reset_i       : clock, synchronous active-high reset
//   disp*_i              : dispatch op, destination tag, sources, val3
//   full_o               : every entry valid (no credit for a same-cycle issue)
//   cdb*_i               : common data bus broadcast
//   reservationStation*_o, RSVal3_o : selected entry, zero when none ready
//   readyRS_o            : an entry is presented
//   stallRS_i            : issue stage cannot capture this cycle
module alu_reservation_station
  import issue_pkg::*;
#(
  parameter int ROBsize    = 16,
  parameter int ROBsizeLog = tag_w(ROBsize),
  parameter int RSentries  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  dispValid_i,
  input  logic [CMD_W-1:0]      dispCommands_i,
  input  logic [ROBsizeLog-1:0] dispTag_i,
  input  logic                  dispSrc1Rdy_i,
  input  logic [DATA_W-1:0]     dispSrc1Val_i,
  input  logic                  dispSrc2Rdy_i,
  input  logic [DATA_W-1:0]     dispSrc2Val_i,
  input  logic [DATA_W-1:0]     dispVal3_i,
  output logic                  full_o,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [DATA_W-1:0]     cdbVal_i,
  output logic [DATA_W-1:0]     reservationStationVal1_o,
  output logic [DATA_W-1:0]     reservationStationVal2_o,
  output logic [DATA_W-1:0]     RSVal3_o,
  output logic [CMD_W-1:0]      reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o,
  output logic                  readyRS_o,
  input  logic                  stallRS_i
);

  localparam int IDX_W = $clog2(RSentries);

  rs_entry_t             entries [RSentries];
  logic [ROBsizeLog-1:0] tags    [RSentries];
  logic [RSentries-1:0]  valid_vec, ready_vec, wr_vec, clr_vec;
  logic [IDX_W-1:0]      sel_idx, free_idx;
  logic                  any_ready, any_free, disp_fire, issue_fire;
  rs_src_t               wr_src1, wr_src2;

  assign wr_src1 = '{rdy: dispSrc1Rdy_i, val: dispSrc1Val_i};
  assign wr_src2 = '{rdy: dispSrc2Rdy_i, val: dispSrc2Val_i};

  for (genvar g = 0; g < RSentries; g++) begin : g_slot
    rs_slot #(.TAG_W(ROBsizeLog)) u_slot (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .wr_i        (wr_vec[g]),
      .wr_cmd_i    (dispCommands_i),
      .wr_tag_i    (dispTag_i),
      .wr_src1_i   (wr_src1),
      .wr_src2_i   (wr_src2),
      .wr_val3_i   (dispVal3_i),
      .clr_i       (clr_vec[g]),
      .cdb_valid_i (cdbValid_i),
      .cdb_tag_i   (cdbTag_i),
      .cdb_val_i   (cdbVal_i),
      .entry_o     (entries[g]),
      .tag_o       (tags[g]),
      .ready_o     (ready_vec[g])
    );
    assign valid_vec[g] = entries[g].valid;
  end

  // Fixed-priority encoders: scanning downward lets the lowest index win.
  always_comb begin
    sel_idx  = '0;
    free_idx = '0;
    for (int i = RSentries - 1; i >= 0; i--) begin
      if (ready_vec[i])  sel_idx  = IDX_W'(i);
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_ready  = |ready_vec;
  assign any_free   = ~&valid_vec;
  assign full_o     = ~any_free;
  assign disp_fire  = dispValid_i & any_free;
  assign issue_fire = any_ready & ~stallRS_i;

  // The chosen free slot is never the issuing slot: the issuer is valid.
  always_comb begin
    wr_vec  = '0;
    clr_vec = '0;
    if (disp_fire)  wr_vec[free_idx] = 1'b1;
    if (issue_fire) clr_vec[sel_idx] = 1'b1;
  end

  always_comb begin
    reservationStationVal1_o     = '0;
    reservationStationVal2_o     = '0;
    RSVal3_o                     = '0;
    reservationStationCommands_o = '0;
    reservationStationTag_o      = '0;
    if (any_ready) begin
      reservationStationVal1_o     = entries[sel_idx].src1.val;
      reservationStationVal2_o     = entries[sel_idx].src2.val;
      RSVal3_o                     = entries[sel_idx].val3;
      reservationStationCommands_o = entries[sel_idx].cmd;
      reservationStationTag_o      = tags[sel_idx];
    end
  end

  assign readyRS_o = any_ready;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - self-checking bench for alu_reservation_station
module tb_alu_reservation_station;

  localparam int TW = 5;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          dispValid_i;
  logic [9:0]    dispCommands_i;
  logic [TW-1:0] dispTag_i;
  logic          dispSrc1Rdy_i;
  logic [63:0]   dispSrc1Val_i;
  logic          dispSrc2Rdy_i;
  logic [63:0]   dispSrc2Val_i;
  logic [63:0]   dispVal3_i;
  logic          full_o;
  logic          cdbValid_i;
  logic [TW-1:0] cdbTag_i;
  logic [63:0]   cdbVal_i;
  logic [63:0]   reservationStationVal1_o;
  logic [63:0]   reservationStationVal2_o;
  logic [63:0]   RSVal3_o;
  logic [9:0]    reservationStationCommands_o;
  logic [TW-1:0] reservationStationTag_o;
  logic          readyRS_o;
  logic          stallRS_i;

  alu_reservation_station #(.ROBsize(16), .RSentries(4)) dut (
    .clk_i                        (clk_i),
    .reset_i                      (reset_i),
    .dispValid_i                  (dispValid_i),
    .dispCommands_i               (dispCommands_i),
    .dispTag_i                    (dispTag_i),
    .dispSrc1Rdy_i                (dispSrc1Rdy_i),
    .dispSrc1Val_i                (dispSrc1Val_i),
    .dispSrc2Rdy_i                (dispSrc2Rdy_i),
    .dispSrc2Val_i                (dispSrc2Val_i),
    .dispVal3_i                   (dispVal3_i),
    .full_o                       (full_o),
    .cdbValid_i                   (cdbValid_i),
    .cdbTag_i                     (cdbTag_i),
    .cdbVal_i                     (cdbVal_i),
    .reservationStationVal1_o     (reservationStationVal1_o),
    .reservationStationVal2_o     (reservationStationVal2_o),
    .RSVal3_o                     (RSVal3_o),
    .reservationStationCommands_o (reservationStationCommands_o),
    .reservationStationTag_o      (reservationStationTag_o),
    .readyRS_o                    (readyRS_o),
    .stallRS_i                    (stallRS_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          disp_v;
    logic [9:0]    cmd;
    logic [TW-1:0] tag;
    logic          s1r;
    logic [63:0]   s1v;
    logic          s2r;
    logic [63:0]   s2v;
    logic [63:0]   v3;
    logic          cdb_v;
    logic [TW-1:0] cdb_t;
    logic [63:0]   cdb_val;
    logic          stall;
  } in_t;

  typedef struct {
    logic          rdy;
    logic          full;
    logic [63:0]   v1;
    logic [63:0]   v2;
    logic [63:0]   v3;
    logic [9:0]    cmd;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t ex;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  function automatic in_t idle(input logic stall);
    in_t r;
    r = '{disp_v: 1'b0, cmd: '0, tag: '0, s1r: 1'b0, s1v: '0, s2r: 1'b0, s2v: '0,
          v3: '0, cdb_v: 1'b0, cdb_t: '0, cdb_val: '0, stall: stall};
    return r;
  endfunction

  function automatic in_t disp(input logic [9:0] cmd, input logic [TW-1:0] tag,
                               input logic s1r, input logic [63:0] s1v,
                               input logic s2r, input logic [63:0] s2v,
                               input logic [63:0] v3);
    in_t r;
    r        = idle(1'b0);
    r.disp_v = 1'b1;
    r.cmd    = cmd;
    r.tag    = tag;
    r.s1r    = s1r;
    r.s1v    = s1v;
    r.s2r    = s2r;
    r.s2v    = s2v;
    r.v3     = v3;
    return r;
  endfunction

  function automatic in_t cdb(input logic [TW-1:0] t, input logic [63:0] val,
                              input logic stall);
    in_t r;
    r         = idle(stall);
    r.cdb_v   = 1'b1;
    r.cdb_t   = t;
    r.cdb_val = val;
    return r;
  endfunction

  function automatic exp_t none(input logic full);
    exp_t e;
    e = '{rdy: 1'b0, full: full, v1: '0, v2: '0, v3: '0, cmd: '0, tag: '0};
    return e;
  endfunction

  function automatic exp_t sel(input logic [63:0] v1, input logic [63:0] v2,
                               input logic [63:0] v3, input logic [9:0] cmd,
                               input logic [TW-1:0] tag, input logic full);
    exp_t e;
    e = '{rdy: 1'b1, full: full, v1: v1, v2: v2, v3: v3, cmd: cmd, tag: tag};
    return e;
  endfunction

  task automatic add(input in_t i, input exp_t e);
    vec_t v;
    v.in = i;
    v.ex = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input in_t i);
    dispValid_i    = i.disp_v;
    dispCommands_i = i.cmd;
    dispTag_i      = i.tag;
    dispSrc1Rdy_i  = i.s1r;
    dispSrc1Val_i  = i.s1v;
    dispSrc2Rdy_i  = i.s2r;
    dispSrc2Val_i  = i.s2v;
    dispVal3_i     = i.v3;
    cdbValid_i     = i.cdb_v;
    cdbTag_i       = i.cdb_t;
    cdbVal_i       = i.cdb_val;
    stallRS_i      = i.stall;
  endtask

  task automatic check_outputs(input string pfx, input exp_t e);
    chk({pfx, ".ready"}, 64'(readyRS_o), 64'(e.rdy));
    chk({pfx, ".full"},  64'(full_o),    64'(e.full));
    chk({pfx, ".val1"},  reservationStationVal1_o, e.v1);
    chk({pfx, ".val2"},  reservationStationVal2_o, e.v2);
    chk({pfx, ".val3"},  RSVal3_o, e.v3);
    chk({pfx, ".cmd"},   64'(reservationStationCommands_o), 64'(e.cmd));
    chk({pfx, ".tag"},   64'(reservationStationTag_o), 64'(e.tag));
  endtask

  // Apply one cycle of inputs, then sample the registered-state outputs after the edge.
  task automatic step(input string pfx, input in_t i, input exp_t e);
    drive(i);
    @(posedge clk_i);
    #1;
    check_outputs(pfx, e);
  endtask

  initial begin
    in_t bp;

    // Basic dispatch -> ready -> issue.
    add(disp(10, 3, 1, 15, 1, 3, 7),              sel(15, 3, 7, 10, 3, 0));
    add(idle(0),                                   none(0));
    // Wait on tag 5, resolve by CDB, then hold under stall for three cycles.
    add(disp(1, 4, 0, 5, 1, 4, 0),                 none(0));
    add(cdb(5, 64'h20, 1),                         sel(64'h20, 4, 0, 1, 4, 0));
    add(idle(1),                                   sel(64'h20, 4, 0, 1, 4, 0));
    add(idle(1),                                   sel(64'h20, 4, 0, 1, 4, 0));
    add(idle(0),                                   none(0));
    // Fill all four entries with waiting ops; fifth dispatch is dropped.
    add(disp(1, 1, 0, 10, 1, 64'h100, 64'h200),    none(0));
    add(disp(2, 2, 0, 11, 1, 64'h101, 64'h201),    none(0));
    add(disp(3, 3, 0, 12, 1, 64'h102, 64'h202),    none(0));
    add(disp(4, 4, 0, 9,  1, 64'h103, 64'h203),    none(1));
    add(disp(5, 5, 1, 64'h55, 1, 64'h56, 64'h57),  none(1));
    // Resolve entry 2 alone; full drops the cycle after the accept.
    add(cdb(12, 64'h77, 0),                        sel(64'h77, 64'h102, 64'h202, 3, 3, 1));
    add(idle(0),                                   none(0));
    // Refill slot 2 waiting on tag 9, then one broadcast wakes slots 2 and 3.
    add(disp(6, 6, 0, 9, 1, 64'h66, 64'h76),       none(1));
    add(cdb(9, 64'h99, 1),                         sel(64'h99, 64'h66, 64'h76, 6, 6, 1));
    add(idle(1),                                   sel(64'h99, 64'h66, 64'h76, 6, 6, 1));
    add(idle(0),                                   sel(64'h99, 64'h103, 64'h203, 4, 4, 0));
    add(idle(0),                                   none(0));
    // Wake slot 0, then issue it while dispatching into a free slot.
    add(cdb(10, 64'hA0, 0),                        sel(64'hA0, 64'h100, 64'h200, 1, 1, 0));
    add(disp(5, 7, 1, 64'h11, 1, 64'h22, 64'h33),  sel(64'h11, 64'h22, 64'h33, 5, 7, 0));
    add(idle(0),                                   none(0));

    drive(idle(0));
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("reset", none(0));
    reset_i = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      step($sformatf("r%0d", k), vecs[k].in, vecs[k].ex);

    // Reset in the middle of operation discards a ready entry and a same-cycle dispatch.
    step("pre_rst", disp(2, 2, 1, 64'hAA, 1, 64'hBB, 64'hCC), sel(64'hAA, 64'hBB, 64'hCC, 2, 2, 0));
    drive(disp(3, 3, 1, 1, 1, 2, 3));
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    check_outputs("mid_rst", none(0));

    // Dispatch a source waiting on tag 6 while tag 6 broadcasts.
    bp         = disp(2, 8, 0, 6, 1, 64'h44, 64'h45);
    bp.cdb_v   = 1'b1;
    bp.cdb_t   = 6;
    bp.cdb_val = 64'h55;
`ifdef RS_DISPATCH_BYPASS_EN
    step("bypass0", bp,      sel(64'h55, 64'h44, 64'h45, 2, 8, 0));
    step("bypass1", idle(1), sel(64'h55, 64'h44, 64'h45, 2, 8, 0));
`else
    step("bypass0", bp,      none(0));
    step("bypass1", idle(1), none(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Multi-entry ALU reservation station; the sending end of the RS→issue/execute handshake.
- Accepts renamed ALU ops from dispatch and snoops the CDB to resolve operand tags.
- Presents one fully-ready entry per cycle to the ALU issue/execute stage.
- Entry is released only when the issue stage is not stalling.

Parameters:
- ROBsize, 16, ROB entry count.
- ROBsizeLog, $clog2(ROBsize+1), tag width.
- RSentries, 4, station depth; power of two, ≥2.

Ports:
- clk_i in 1: clock.
- reset_i in 1: synchronous, active-high reset.
- dispValid_i in 1: dispatch op valid this cycle.
- dispCommands_i in 10: op commands; bits [4:2] are the ALU control.
- dispTag_i in ROBsizeLog: destination ROB tag.
- dispSrc1Rdy_i in 1: src1 holds a value (1) or a tag (0).
- dispSrc1Val_i in 64: value if ready; low ROBsizeLog bits = producer tag otherwise.
- dispSrc2Rdy_i in 1 / dispSrc2Val_i in 64: same encoding for src2.
- dispVal3_i in 64: pass-through third value; never waits on CDB.
- full_o out 1: all entries valid.
- cdbValid_i in 1 / cdbTag_i in ROBsizeLog / cdbVal_i in 64: common data bus broadcast.
- reservationStationVal1_o out 64: selected entry src1.
- reservationStationVal2_o out 64: selected entry src2.
- RSVal3_o out 64: selected entry val3.
- reservationStationCommands_o out 10: selected entry commands.
- reservationStationTag_o out ROBsizeLog: selected entry destination tag.
- readyRS_o out 1: a selected entry is valid.
- stallRS_i in 1: issue stage cannot capture this cycle.

Behaviour:
- Per entry state: valid, commands, dest tag, per-source {rdy, val/tag}, val3.
- Ready = valid & src1.rdy & src2.rdy.
- Select: lowest-index ready entry, fixed priority. Outputs driven combinationally from registered entry state.
- readyRS_o = any entry ready. When readyRS_o=0, data outputs are 0.
- Issue accepted iff readyRS_o & ~stallRS_i in the same cycle. On accept, the selected entry's valid clears at the clock edge.
- When stallRS_i=1, the selection holds unchanged while the entry set is unchanged. A newly ready lower-index entry may preempt the selection; the issue stage latches only on ~stall, so this is safe.
- Dispatch:
  - If dispValid_i & ~full_o, write the lowest-index free entry (free per the current state).
  - Dispatch while full_o=1 is dropped; upstream must honour full_o.
  - full_o is computed from the current state and does not credit a same-cycle issue.
- Latency: an op dispatched with both sources ready asserts readyRS_o the next cycle. Minimum dispatch→issue accept is 1 cycle.
- CDB snoop: each valid entry source with rdy=0 and tag==cdbTag_i while cdbValid_i=1 captures cdbVal_i and sets rdy at the edge. The entry becomes ready the following cycle.
- Simultaneous issue + dispatch: legal. The dispatch goes to a currently free slot, never the issuing slot.
- Simultaneous issue + CDB: the issuing entry is already ready, so no effect.
- Multiple entries may match one CDB tag; all capture.
- Reset (including mid-operation): all valid=0, readyRS_o=0, full_o=0, all data outputs 0. In-flight entries are discarded.

Optional Feature:
- Macro: RS_DISPATCH_BYPASS_EN.
- Defined: a dispatching source with rdy=0 whose tag matches a same-cycle cdbValid_i/cdbTag_i is written with rdy=1 and the cdbVal_i value.
- Undefined: the source is written unready with its tag. Upstream rename guarantees no producer broadcasts in the dispatch cycle of a consumer.

Decomposition:
- Shared package issue_pkg:
  - CMD_W=10, DATA_W=64.
  - Tag-width function.
  - rs_src_t struct {rdy, val}.
  - rs_entry_t struct.
- Sub-module rs_slot: one entry. Handles write-on-dispatch, CDB snoop per source, clear-on-issue. Exposes the entry and its ready flag.
- Top level: free/ready priority encoders and output mux.

Test Plan:
- Reset, then dispatch cmd=10, tag=3, src1=15 rdy, src2=3 rdy, val3=7, stall=0 → next cycle readyRS_o=1 with vals 15/3/7, cmd 10, tag 3; following cycle readyRS_o=0.
- Dispatch src1 tag=5 unready, src2=4 rdy → readyRS_o stays 0. CDB tag=5 val=0x20 → readyRS_o=1 the next cycle with val1=0x20.
- Hold stallRS_i=1 with an entry ready for 3 cycles → outputs stable, entry retained. Drop stall → accepted, entry freed.
- Fill 4 entries with unready sources → full_o=1; 5th dispatch dropped. One CDB resolves entry 2 and it issues → full_o=0 the cycle after the accept.
- Two entries waiting on tag 9; CDB tag 9 → both ready; entry 0 issues first, entry 1 on the next non-stalled cycle.
- With RS_DISPATCH_BYPASS_EN: dispatch src1 tag=6 while CDB tag=6 val=0x55 → ready next cycle, val1=0x55. Without the macro, the same stimulus leaves the entry waiting.
